// File: rtl/blob_label_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : blob_label_pingpong
// Description : Ping-pong label frame store. The pass-1 labels of frame N are
//               written to one bank while frame N-1 is read from the other
//               bank at the same x,y position. Frame geometry is measured per
//               frame, and range and line-length errors are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module blob_label_pingpong #(
  parameter int LABEL_W = 8,
  parameter int X_W     = 8,
  parameter int Y_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_valid,
  input  logic               data_valid,
  input  logic [LABEL_W-1:0] label_in,
  output logic [LABEL_W-1:0] label_out,
  output logic               o_frame_valid,
  output logic               o_data_valid,
  output logic               rd_bank_valid,
  output logic [X_W:0]       frame_cols,
  output logic [Y_W:0]       frame_rows,
  output logic               overflow,
  output logic               geom_err
);

  localparam int             c_AW    = 1 + X_W + Y_W;
  localparam int             c_DEPTH = 1 << c_AW;
  localparam logic [X_W:0]   c_X_MAX = {1'b1, {X_W{1'b0}}};
  localparam logic [Y_W:0]   c_Y_MAX = {1'b1, {Y_W{1'b0}}};
  localparam logic [X_W:0]   c_X_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic [Y_W:0]   c_Y_ONE = {{Y_W{1'b0}}, 1'b1};

  logic [LABEL_W-1:0] r_mem [c_DEPTH];
  logic [LABEL_W-1:0] r_ram_q;

  logic               r_fv;
  logic               r_pix;
  logic [X_W:0]       r_x;
  logic [Y_W:0]       r_y;
  logic               r_wr_bank;
  logic [X_W:0]       r_cur_cols;
  logic               r_overflow;
  logic               r_geom_err;
  logic               r_rd_bank_valid;
  logic [X_W:0]       r_frame_cols;
  logic [Y_W:0]       r_frame_rows;
  logic               r_rd_ok;

  logic               w_pix;
  logic               w_line_end;
  logic               w_frame_start;
  logic               w_frame_end;
  logic               w_x_sat;
  logic               w_y_sat;
  logic               w_in_range;
  logic [X_W:0]       w_x_inc;
  logic [Y_W:0]       w_y_inc;
  logic [Y_W:0]       w_y_next;
  logic               w_ovf_set;
  logic               w_geom_set;
  logic               w_ovf_next;
  logic               w_geom_next;
  logic [X_W:0]       w_cols_next;
  logic [c_AW-1:0]    w_wr_addr;
  logic [c_AW-1:0]    w_rd_addr;

  // A line ends whenever the qualified pixel stream drops, which covers
  // data_valid falling, frame_valid falling, or both in the same cycle.
  assign w_pix         = frame_valid & data_valid;
  assign w_line_end    = r_pix & ~w_pix;
  assign w_frame_start = ~r_fv & frame_valid;
  assign w_frame_end   = r_fv & ~frame_valid;

  assign w_x_sat    = (r_x == c_X_MAX);
  assign w_y_sat    = (r_y == c_Y_MAX);
  assign w_in_range = ~w_x_sat & ~w_y_sat;
  assign w_x_inc    = w_x_sat ? r_x : r_x + c_X_ONE;
  assign w_y_inc    = w_y_sat ? r_y : r_y + c_Y_ONE;
  assign w_y_next   = w_line_end ? w_y_inc : r_y;

  assign w_ovf_set   = w_pix & ~w_in_range;
  assign w_geom_set  = w_line_end & (r_y != '0) & (r_x != r_cur_cols);
  assign w_ovf_next  = (w_frame_start ? 1'b0 : r_overflow) | w_ovf_set;
  assign w_geom_next = (w_frame_start ? 1'b0 : r_geom_err) | w_geom_set;

  always_comb begin
    w_cols_next = r_cur_cols;
    if (w_frame_start) begin
      w_cols_next = '0;
    end
    if (w_line_end && (r_y == '0)) begin
      w_cols_next = r_x;
    end
  end

  assign w_wr_addr = {r_wr_bank,  r_y[Y_W-1:0], r_x[X_W-1:0]};
  assign w_rd_addr = {~r_wr_bank, r_y[Y_W-1:0], r_x[X_W-1:0]};

  // Storage array carries no reset; validity of the read is tracked in r_rd_ok.
  always_ff @(posedge clk) begin
    if (w_pix && w_in_range) begin
      r_mem[w_wr_addr] <= label_in;
    end
    if (w_pix) begin
      r_ram_q <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fv            <= 1'b0;
      r_pix           <= 1'b0;
      r_x             <= '0;
      r_y             <= '0;
      r_wr_bank       <= 1'b0;
      r_cur_cols      <= '0;
      r_overflow      <= 1'b0;
      r_geom_err      <= 1'b0;
      r_rd_bank_valid <= 1'b0;
      r_frame_cols    <= '0;
      r_frame_rows    <= '0;
      r_rd_ok         <= 1'b0;
    end else begin
      r_fv       <= frame_valid;
      r_pix      <= w_pix;
      r_overflow <= w_ovf_next;
      r_geom_err <= w_geom_next;
      r_cur_cols <= w_cols_next;

      if (w_pix) begin
        r_rd_ok <= r_rd_bank_valid & w_in_range;
      end

      if (w_frame_end) begin
        r_x             <= '0;
        r_y             <= '0;
        r_wr_bank       <= ~r_wr_bank;
        r_frame_rows    <= w_y_next;
        r_frame_cols    <= w_cols_next;
        r_rd_bank_valid <= (w_y_next != '0) & ~w_ovf_next & ~w_geom_next;
      end else if (w_line_end) begin
        r_x <= '0;
        r_y <= w_y_inc;
      end else if (w_pix) begin
        r_x <= w_x_inc;
      end
    end
  end

  assign label_out     = r_rd_ok ? r_ram_q : '0;
  assign o_frame_valid = r_fv;
  assign o_data_valid  = r_pix;
  assign rd_bank_valid = r_rd_bank_valid;
  assign frame_cols    = r_frame_cols;
  assign frame_rows    = r_frame_rows;
  assign overflow      = r_overflow;
  assign geom_err      = r_geom_err;

endmodule
`default_nettype wire

// File: tb/tb_blob_label_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : tb_blob_label_pingpong
// Description : Directed self-checking bench for the ping-pong label store,
//               built with a 4-pixel by 4-line address range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blob_label_pingpong;

  localparam int LW = 8;
  localparam int XW = 2;
  localparam int YW = 2;

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b0;
  logic          frame_valid = 1'b0;
  logic          data_valid  = 1'b0;
  logic [LW-1:0] label_in    = '0;
  logic [LW-1:0] label_out;
  logic          o_frame_valid;
  logic          o_data_valid;
  logic          rd_bank_valid;
  logic [XW:0]   frame_cols;
  logic [YW:0]   frame_rows;
  logic          overflow;
  logic          geom_err;

  int   n_vec  = 0;
  int   n_fail = 0;
  logic e_ovf  = 1'b0;

  always #5 clk = ~clk;

  blob_label_pingpong #(
    .LABEL_W (LW),
    .X_W     (XW),
    .Y_W     (YW)
  ) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_valid   (frame_valid),
    .data_valid    (data_valid),
    .label_in      (label_in),
    .label_out     (label_out),
    .o_frame_valid (o_frame_valid),
    .o_data_valid  (o_data_valid),
    .rd_bank_valid (rd_bank_valid),
    .frame_cols    (frame_cols),
    .frame_rows    (frame_rows),
    .overflow      (overflow),
    .geom_err      (geom_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fv, input logic dv, input logic [LW-1:0] lbl);
    frame_valid = fv;
    data_valid  = dv;
    label_in    = lbl;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    step(1'b1, 1'b0, '0);
    e_ovf = 1'b0;
    chk("ofv_rise", o_frame_valid, 1);
    chk("ovf_clr", overflow, 0);
    chk("geom_clr", geom_err, 0);
  endtask

  // exp0 == 0 means the read bank is not valid; columns/rows >= 4 are out of range.
  task automatic pix_line(input int len, input int lbl0, input int exp0, input int row);
    for (int i = 0; i < len; i++) begin
      step(1'b1, 1'b1, LW'(lbl0 + i));
      if (i >= 4 || row >= 4) e_ovf = 1'b1;
      chk("odv", o_data_valid, 1);
      chk("label", label_out, (exp0 == 0 || i >= 4 || row >= 4) ? 0 : exp0 + i);
      chk("ovf", overflow, e_ovf);
    end
  endtask

  task automatic chk_end(input int rbv, input int rows, input int cols);
    chk("rbv", rd_bank_valid, rbv);
    chk("rows", frame_rows, rows);
    chk("cols", frame_cols, cols);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("rst_label", label_out, 0);
    chk("rst_odv", o_data_valid, 0);
    chk("rst_ofv", o_frame_valid, 0);
    chk_end(0, 0, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_geom", geom_err, 0);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // Frame A: 4x3 labels 1..12, nothing valid to read yet
    frame_start();
    for (int r = 0; r < 3; r++) begin
      pix_line(4, 1 + 4 * r, 0, r);
      step(1'b1, 1'b0, '0);
    end
    step(1'b0, 1'b0, '0);
    chk("ofv_fall", o_frame_valid, 0);
    chk_end(1, 3, 4);
    step(1'b0, 1'b0, '0);

    // Frame B: 4x3 labels 21..32, reads back frame A
    frame_start();
    for (int r = 0; r < 3; r++) begin
      pix_line(4, 21 + 4 * r, 1 + 4 * r, r);
      step(1'b1, 1'b0, '0);
      if (r == 0) begin
        chk("hold_odv", o_data_valid, 0);
        chk("hold_label", label_out, 4);
      end
    end
    step(1'b0, 1'b0, '0);
    chk_end(1, 3, 4);
    step(1'b0, 1'b0, '0);

    // Frame C: 5-pixel lines overflow the 4-column range; reads frame B
    frame_start();
    for (int r = 0; r < 3; r++) begin
      pix_line(5, 41 + 5 * r, 21 + 4 * r, r);
      step(1'b1, 1'b0, '0);
    end
    step(1'b0, 1'b0, '0);
    chk_end(0, 3, 4);
    chk("ovf_sticky", overflow, 1);
    chk("geom_c", geom_err, 0);
    step(1'b0, 1'b0, '0);
    chk("ovf_gap", overflow, 1);

    // Frame D: line lengths 4,4,3
    frame_start();
    pix_line(4, 61, 0, 0);
    step(1'b1, 1'b0, '0);
    chk("geom_l0", geom_err, 0);
    pix_line(4, 65, 0, 1);
    step(1'b1, 1'b0, '0);
    chk("geom_l1", geom_err, 0);
    pix_line(3, 69, 0, 2);
    step(1'b1, 1'b0, '0);
    chk("geom_l2", geom_err, 1);
    step(1'b0, 1'b0, '0);
    chk_end(0, 3, 4);
    chk("geom_end", geom_err, 1);
    step(1'b0, 1'b0, '0);
    chk("geom_gap", geom_err, 1);

    // Frame E: data_valid and frame_valid fall together on the last line
    frame_start();
    for (int r = 0; r < 2; r++) begin
      pix_line(4, 81 + 4 * r, 0, r);
      step(1'b1, 1'b0, '0);
    end
    pix_line(4, 89, 0, 2);
    step(1'b0, 1'b0, '0);
    chk_end(1, 3, 4);
    step(1'b0, 1'b0, '0);

    // Frame F: reads frame E (single swap), then reset mid-line
    frame_start();
    pix_line(2, 101, 81, 0);
    reset_n     = 1'b0;
    frame_valid = 1'b0;
    data_valid  = 1'b0;
    #1;
    chk("arst_label", label_out, 0);
    chk("arst_odv", o_data_valid, 0);
    chk("arst_ofv", o_frame_valid, 0);
    chk_end(0, 0, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_geom", geom_err, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
    chk("post_rst_rbv", rd_bank_valid, 0);

    // Frame G: nothing valid to read after reset
    frame_start();
    for (int r = 0; r < 3; r++) begin
      pix_line(4, 111 + 4 * r, 0, r);
      step(1'b1, 1'b0, '0);
    end
    step(1'b0, 1'b0, '0);
    chk_end(1, 3, 4);
    step(1'b0, 1'b0, '0);

    // Zero-line frame
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk_end(0, 0, 0);
    step(1'b0, 1'b0, '0);

    // Five single-pixel lines overflow the 4-row range
    frame_start();
    for (int r = 0; r < 5; r++) begin
      pix_line(1, 130 + r, 0, r);
      step(1'b1, 1'b0, '0);
    end
    step(1'b0, 1'b0, '0);
    chk_end(0, 4, 1);
    chk("ovf_y", overflow, 1);
    step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
